// File: rtl/mac_pkg.sv
// mac_pkg: shared types, defaults and saturation helpers for the mac_acc_36
// product accumulator.
//   PROD_W_DEF / ACC_W_DEF : default product and accumulator widths
//   TREE_LAT               : register stages in the per-lane adder tree
//   SAT_W                  : working width of the saturation helpers (max ACC_W)
//   state_t                : frame FSM states
//   sat_add / sat_ovf      : clamp acc+x to a signed w-bit range / flag the clamp
package mac_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int TREE_LAT   = 3;
    localparam int SAT_W      = 64;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

    // Largest positive value of a signed w-bit number, held at SAT_W bits.
    function automatic logic signed [SAT_W-1:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Operands arrive sign-extended from w bits, so the SAT_W-bit add cannot
    // wrap; it plays the role of the w+1-bit intermediate sum.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = acc + x;
        hi = sat_max(w);
        lo = ~hi;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

    function automatic logic sat_ovf(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        s  = acc + x;
        hi = sat_max(w);
        return (s > hi) || (s < ~hi);
    endfunction

endpackage

// File: rtl/adder_tree_36.sv
// adder_tree_36: three-stage signed reduction of 36 PROD_W-bit products.
//   clk, rst_n          : clock, async active-low reset (sideband only)
//   in_valid, in_first  : beat valid and first-beat-of-frame tag
//   prod                : 36 packed products, lane j at [PROD_W*j +: PROD_W]
//   out_valid, out_first: sideband delayed by three cycles
//   sum                 : signed total, PROD_W+6 bits
module adder_tree_36 #(
    parameter int PROD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic [PROD_W*36-1:0] prod,
    output logic                 out_valid,
    output logic                 out_first,
    output logic [PROD_W+5:0]    sum
);

    localparam int PW = PROD_W + 3;
    localparam int SW = PROD_W + 6;

    logic signed [PROD_W-1:0] prod_p0 [36];
    logic signed [PW-1:0]     part_c  [6];
    logic signed [PW-1:0]     part_p1 [6];
    logic signed [SW-1:0]     total_c;
    logic signed [SW-1:0]     sum_p2;
    logic vld_p0, vld_p1, vld_p2;
    logic first_p0, first_p1, first_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            first_p0 <= 1'b0;
            first_p1 <= 1'b0;
            first_p2 <= 1'b0;
        end else begin
            vld_p0   <= in_valid;
            vld_p1   <= vld_p0;
            vld_p2   <= vld_p1;
            first_p0 <= in_first;
            first_p1 <= first_p0;
            first_p2 <= first_p1;
        end
    end

    // S1: raw products
    always_ff @(posedge clk) begin
        for (int j = 0; j < 36; j++)
            prod_p0[j] <= prod[PROD_W*j +: PROD_W];
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            part_c[k] = '0;
            for (int m = 0; m < 6; m++)
                part_c[k] = part_c[k] + PW'(prod_p0[6*k+m]);
        end
    end

    // S2: six partial sums of six products each
    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++)
            part_p1[k] <= part_c[k];
    end

    always_comb begin
        total_c = '0;
        for (int k = 0; k < 6; k++)
            total_c = total_c + SW'(part_p1[k]);
    end

    // S3: lane total
    always_ff @(posedge clk) begin
        sum_p2 <= total_c;
    end

    assign out_valid = vld_p2;
    assign out_first = first_p2;
    assign sum       = sum_p2;

endmodule

// File: rtl/mac_acc_36.sv
// mac_acc_36: reduces two 36-lane product vectors per beat and accumulates
// them over a frame, presenting two saturated dot products downstream.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : beat handshake; in_last marks the final beat
//   prod1, prod2        : lane-1 / lane-2 products, lane i at [PROD_W*i-1 -: PROD_W]
//   res_valid/res_ready : result handshake
//   res1, res2          : signed frame sums, saturated to ACC_W bits
//   res_ovf             : per-lane sticky saturation flag (bit0 lane 1)
module mac_acc_36
    import mac_pkg::*;
#(
    parameter int N      = 36,
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [PROD_W*N-1:0]   prod1,
    input  logic [PROD_W*N-1:0]   prod2,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res1,
    output logic [ACC_W-1:0]      res2,
    output logic [1:0]            res_ovf
);

    localparam int TSW = PROD_W + 6;

    state_t      state, state_nxt;
    logic [2:0]  drain_cnt;
    logic        accept;
    logic        drain_done;

    logic [PROD_W*N-1:0]     prod_l [2];
    logic signed [TSW-1:0]   tsum   [2];
    logic signed [ACC_W-1:0] acc_l  [2];
    logic [1:0]              tvld, tfirst, ovf_l;

    assign accept     = in_valid && in_ready;
    assign prod_l[0]  = prod1;
    assign prod_l[1]  = prod2;
    // The last beat reaches the accumulator TREE_LAT edges after acceptance;
    // one more edge lets it settle before capture.
    assign drain_done = (drain_cnt == 3'(TREE_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst_n gates in_ready so no beat is offered while reset is held.
    always_comb begin
        in_ready  = rst_n && ((state == IDLE) || (state == ACCUM));
        res_valid = (state == RESULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_cnt <= 3'd0;
        else if (accept && in_last)
            drain_cnt <= 3'd0;
        else if (state == DRAIN)
            drain_cnt <= drain_cnt + 3'd1;
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic signed [ACC_W-1:0] acc;
        logic                    ovf;

        adder_tree_36 #(.PROD_W(PROD_W)) u_tree (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (accept),
            .in_first  (state == IDLE),
            .prod      (prod_l[l]),
            .out_valid (tvld[l]),
            .out_first (tfirst[l]),
            .sum       (tsum[l])
        );

        // Accumulator stage: first beat loads, later beats saturate-add.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (tvld[l]) begin
                if (tfirst[l]) begin
                    acc <= ACC_W'(tsum[l]);
                    ovf <= 1'b0;
                end else begin
                    acc <= ACC_W'(sat_add(SAT_W'(acc), SAT_W'(tsum[l]), ACC_W));
                    ovf <= ovf | sat_ovf(SAT_W'(acc), SAT_W'(tsum[l]), ACC_W);
                end
            end
        end

        assign acc_l[l] = acc;
        assign ovf_l[l] = ovf;
    end

    // Result register: captured once per frame, held through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res1    <= '0;
            res2    <= '0;
            res_ovf <= 2'b00;
        end else if ((state == DRAIN) && drain_done) begin
            res1    <= acc_l[0];
            res2    <= acc_l[1];
            res_ovf <= ovf_l;
        end
    end

endmodule

// File: tb/tb_mac_acc_36.sv
// tb_mac_acc_36: scoreboard bench for mac_acc_36. Instance a uses ACC_W=32,
// instance b uses ACC_W=24 for saturation. Expected results are queued when a
// frame is issued; monitors pop and compare on every result handshake.
module tb_mac_acc_36;

    localparam int N  = 36;
    localparam int PW = 16;
    localparam int VW = N * PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    iv = 2'b00;
    wire  [1:0]    ir;
    wire  [1:0]    rv;
    logic          in_last = 1'b0;
    logic          rr = 1'b1;
    logic [VW-1:0] prod1 = '0;
    logic [VW-1:0] prod2 = '0;
    wire  [31:0]   ra1, ra2;
    wire  [23:0]   rb1, rb2;
    wire  [1:0]    oa, ob;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_edge = 0;

    typedef struct {
        longint r1;
        longint r2;
        int     ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    mac_acc_36 #(.N(N), .PROD_W(PW), .ACC_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_last(in_last), .prod1(prod1), .prod2(prod2),
        .res_valid(rv[0]), .res_ready(rr), .res1(ra1), .res2(ra2), .res_ovf(oa)
    );

    mac_acc_36 #(.N(N), .PROD_W(PW), .ACC_W(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_last(in_last), .prod1(prod1), .prod2(prod2),
        .res_valid(rv[1]), .res_ready(rr), .res1(rb1), .res2(rb2), .res_ovf(ob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && rv[0] && rr) begin
            if (qa.size() == 0)
                chk("a_unexpected_result", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_res1", $signed(ra1), e.r1);
                chk("a_res2", $signed(ra2), e.r2);
                chk("a_ovf", oa, e.ovf);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && rv[1] && rr) begin
            if (qb.size() == 0)
                chk("b_unexpected_result", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_res1", $signed(rb1), e.r1);
                chk("b_res2", $signed(rb2), e.r2);
                chk("b_ovf", ob, e.ovf);
            end
        end
    end

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int j = 0; j < N; j++) r[PW*j +: PW] = PW'(v);
        return r;
    endfunction

    // Lane i (1-based) carries mult*i.
    function automatic logic [VW-1:0] ramp(input int mult);
        logic [VW-1:0] r;
        for (int j = 0; j < N; j++) r[PW*j +: PW] = PW'(mult * (j + 1));
        return r;
    endfunction

    function automatic longint sum_lanes(input logic [VW-1:0] v);
        longint s;
        logic signed [PW-1:0] t;
        s = 0;
        for (int j = 0; j < N; j++) begin
            t = v[PW*j +: PW];
            s += t;
        end
        return s;
    endfunction

    task automatic beat(input int sel, input logic [VW-1:0] p1,
                        input logic [VW-1:0] p2, input logic last);
        int n;
        prod1 = p1;
        prod2 = p2;
        in_last = last;
        iv[sel] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir[sel] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ir[sel]) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_edge = cyc;
        iv[sel] = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_res(input int sel, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rv[sel] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rv[sel]) chk("result_timeout", 0, 1);
        lat = cyc - acc_edge;
    endtask

    initial begin
        int lat;
        int beats [4];
        int first_e [4];
        logic [VW-1:0] a, b;
        longint s1, s2;

        beats = '{1, 3, 2, 4};

        repeat (3) @(negedge clk);
        chk("reset_in_ready_a", ir[0], 0);
        chk("reset_in_ready_b", ir[1], 0);
        chk("reset_res_valid", rv, 0);
        chk("reset_res1", ra1, 0);
        chk("reset_res2", ra2, 0);
        chk("reset_ovf", oa, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", ir[0], 1);
        @(posedge clk);
        #1;

        // single beat, +1 / -1
        qa.push_back(exp_t'{36, -36, 0});
        beat(0, fill(1), fill(-1), 1'b1);
        wait_res(0, lat);
        chk("t1_latency", lat, 4);
        repeat (2) @(posedge clk);
        #1;

        // three beats with a two-cycle gap after the first
        qa.push_back(exp_t'{1998, -3996, 0});
        beat(0, ramp(1), ramp(-2), 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_gap_in_ready", ir[0], 1);
            @(posedge clk);
            #1;
        end
        beat(0, ramp(1), ramp(-2), 1'b0);
        beat(0, ramp(1), ramp(-2), 1'b1);
        @(negedge clk);
        chk("t2_ready_drop", ir[0], 0);
        wait_res(0, lat);
        chk("t2_latency", lat, 4);
        repeat (2) @(posedge clk);
        #1;

        // saturation on the 24-bit instance, then a clean frame
        qb.push_back(exp_t'{8388607, -8388608, 3});
        for (int i = 0; i < 8; i++)
            beat(1, fill(32767), fill(-32768), i == 7);
        wait_res(1, lat);
        chk("t3_latency", lat, 4);
        @(posedge clk);
        #1;
        qb.push_back(exp_t'{36, 36, 0});
        beat(1, fill(1), fill(1), 1'b1);
        wait_res(1, lat);
        repeat (2) @(posedge clk);
        #1;

        // backpressure: hold res_ready low for ten cycles
        rr = 1'b0;
        qa.push_back(exp_t'{108, -180, 0});
        beat(0, fill(3), fill(-5), 1'b1);
        wait_res(0, lat);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_res1", $signed(ra1), 108);
            chk("t4_hold_res2", $signed(ra2), -180);
            chk("t4_hold_in_ready", ir[0], 0);
            chk("t4_hold_res_valid", rv[0], 1);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk);
        #1 rr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_after_res_valid", rv[0], 0);
        chk("t4_after_in_ready", ir[0], 1);
        @(posedge clk);
        #1;

        // reset during DRAIN aborts the frame
        beat(0, fill(7), fill(7), 1'b1);
        @(negedge clk);
        chk("t5_drain_in_ready", ir[0], 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_in_ready", ir[0], 0);
        chk("t5_rst_res_valid", rv[0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_result", rv[0], 0);
        @(posedge clk);
        #1;
        qa.push_back(exp_t'{72, 72, 0});
        beat(0, fill(2), fill(2), 1'b1);
        wait_res(0, lat);
        chk("t5_latency", lat, 4);
        repeat (2) @(posedge clk);
        #1;

        // back-to-back random frames with res_ready tied high
        for (int f = 0; f < 4; f++) begin
            s1 = 0;
            s2 = 0;
            for (int k = 0; k < beats[f]; k++) begin
                for (int j = 0; j < N; j++) begin
                    a[PW*j +: PW] = PW'($urandom);
                    b[PW*j +: PW] = PW'($urandom);
                end
                s1 += sum_lanes(a);
                s2 += sum_lanes(b);
                if (k == beats[f] - 1) qa.push_back(exp_t'{s1, s2, 0});
                beat(0, a, b, k == beats[f] - 1);
                if (k == 0) first_e[f] = acc_edge;
            end
        end
        wait_res(0, lat);
        for (int f = 1; f < 4; f++)
            chk("t6_frame_period", first_e[f] - first_e[f-1], beats[f-1] + 5);
        repeat (4) @(negedge clk);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
